instr_encoder_loader: RTL and testbench

- Inverse of the ALU/CMP instruction decoder: packs instruction fields into 32-bit instruction words and streams them into instruction memory over a word-addressed write port.
- Used by the bench/boot path to fill IMEM with ALUR/ALUI/CMPR/CMPI programs that the decoder then consumes.
- Field-level valid/ready input, one-entry output register with memory back-pressure, load-session FSM with word counter.

---
 rtl/instr_encoder_loader.sv | 141 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Instruction encoder / IMEM loader: packs ALU/CMP fields into 32-bit words
// and streams them into a word-addressed instruction memory.
module instr_encoder_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_WORDS  = 256,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  is_cmp,
   input  logic                  is_imm,
   input  logic [3:0]            fn,
   input  logic [3:0]            rd,
   input  logic [3:0]            rs1,
   input  logic [3:0]            rs2,
   input  logic [15:0]           imm,
   output logic                  mem_wr_en,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  busy,
   output logic                  full
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_FULL
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH+1:0] LIMIT = (ADDR_WIDTH+2)'(MAX_WORDS);

   state_t state;
   state_t state_next;

   logic [3:0]            opcode;
   logic [31:0]           word;
   logic                  complete;
   logic                  accept;
   logic                  restart;
   logic                  room;
   logic                  last;
   logic [ADDR_WIDTH+1:0] inflight;
   logic [ADDR_WIDTH+1:0] count_inc;

   // Field packing: opcode bits 3 and 1 are always set
   always_comb begin
      opcode = {1'b1, ~is_imm, 1'b1, ~is_cmp};
      if (is_imm)
         word = {fn, opcode, imm, rs1, rd};
      else
         word = {fn, opcode, 12'h000, rs2, rs1, rd};
   end

   // Handshake qualifiers; room counts the pending word as already used
   always_comb begin
      complete  = mem_wr_en & mem_ready;
      accept    = in_valid & in_ready;
      restart   = start & ((state == S_IDLE) | (state == S_FULL));
      inflight  = {1'b0, word_count}
                + {{(ADDR_WIDTH+1){1'b0}}, mem_wr_en};
      count_inc = {1'b0, word_count} + (ADDR_WIDTH+2)'(1);
      room      = inflight < LIMIT;
      last      = count_inc == LIMIT;
   end

   // Session state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Session next-state decode
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (start)
               state_next = S_LOAD;
         end
         S_LOAD: begin
            if (complete && last)
               state_next = S_FULL;
            else if (stop)
               state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (!mem_wr_en || mem_ready)
               state_next = S_IDLE;
         end
         S_FULL: begin
            if (start)
               state_next = S_LOAD;
            else if (stop)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Session status and input acceptance
   always_comb begin
      busy     = state != S_IDLE;
      full     = state == S_FULL;
      in_ready = (state == S_LOAD) & (~mem_wr_en | mem_ready) & room;
   end

   // Output register and session counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_wr_en  <= 1'b0;
         mem_addr   <= BASE;
         mem_wdata  <= 32'h0;
         word_count <= '0;
      end else if (restart) begin
         mem_addr   <= BASE;
         word_count <= '0;
      end else begin
         if (complete) begin
            mem_addr   <= mem_addr + ADDR_WIDTH'(1);
            word_count <= count_inc[ADDR_WIDTH:0];
         end
         if (accept) begin
            mem_wr_en <= 1'b1;
            mem_wdata <= word;
         end else if (complete) begin
            mem_wr_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a write scoreboard.
module tb_instr_encoder_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stop;
   logic        in_valid;
   logic        in_ready;
   logic        is_cmp;
   logic        is_imm;
   logic [3:0]  fn;
   logic [3:0]  rd;
   logic [3:0]  rs1;
   logic [3:0]  rs2;
   logic [15:0] imm;
   logic        mem_wr_en;
   logic        mem_ready;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [8:0]  word_count;
   logic        busy;
   logic        full;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;

   logic [39:0] exp_q[$];
   logic [7:0]  exp_addr;

   instr_encoder_loader #(
      .ADDR_WIDTH (8),
      .MAX_WORDS  (4),
      .BASE_ADDR  (0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .is_cmp     (is_cmp),
      .is_imm     (is_imm),
      .fn         (fn),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .imm        (imm),
      .mem_wr_en  (mem_wr_en),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .word_count (word_count),
      .busy       (busy),
      .full       (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] enc(input bit c, input bit i,
                                       input logic [3:0] f,
                                       input logic [3:0] d,
                                       input logic [3:0] s1,
                                       input logic [3:0] s2,
                                       input logic [15:0] im);
      logic [3:0] op;
      op = {1'b1, ~i, 1'b1, ~c};
      if (i)
         return {f, op, im, s1, d};
      return {f, op, 12'h000, s2, s1, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Drive one bundle; push the expected write when it is accepted
   task automatic send(input bit c, input bit i, input logic [3:0] f,
                       input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [15:0] im,
                       input logic [31:0] exp_w, input int lim,
                       output bit ok, output int waits);
      is_cmp   = c;
      is_imm   = i;
      fn       = f;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      imm      = im;
      in_valid = 1'b1;
      waits    = 0;
      #1;
      while (in_ready !== 1'b1 && waits < lim) begin
         @(posedge clk);
         #2;
         waits++;
      end
      ok = (in_ready === 1'b1);
      if (ok) begin
         exp_q.push_back({exp_addr, exp_w});
         exp_addr++;
      end
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every completed write must match the oldest expectation
   always @(negedge clk) begin
      logic [39:0] e;
      if (reset === 1'b0 && mem_wr_en === 1'b1 && mem_ready === 1'b1) begin
         wr_cnt++;
         chk("sb_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_addr", 32'(mem_addr), 32'(e[39:32]));
            chk("sb_data", mem_wdata, e[31:0]);
         end
      end
   end

   bit ok;
   int w;
   int acc;
   int snap;
   logic [31:0] xw;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      in_valid = 1'b0;
      is_cmp = 1'b0;
      is_imm = 1'b0;
      fn = '0;
      rd = '0;
      rs1 = '0;
      rs2 = '0;
      imm = '0;
      mem_ready = 1'b1;
      exp_addr = 8'd0;
      step();
      step();
      chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      reset = 1'b0;
      step();

      // Single ALUR word, latency 1
      pulse_start();
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_count", 32'(word_count), 32'd0);
      send(0, 0, 4'h0, 4'd3, 4'd1, 4'd2, 16'h0, 32'h0F000213, 8, ok, w);
      in_valid = 1'b0;
      chk("alur_wr_en", 32'(mem_wr_en), 32'd1);
      chk("alur_addr", 32'(mem_addr), 32'd0);
      chk("alur_data", mem_wdata, 32'h0F000213);
      step();
      chk("alur_count", 32'(word_count), 32'd1);

      // Three more classes back to back; fourth word fills the session
      send(0, 1, 4'h4, 4'd5, 4'd6, 4'd0, 16'hBEEF, 32'h4BBEEF65, 8, ok, w);
      send(1, 0, 4'h9, 4'd1, 4'd2, 4'd3, 16'h0, 32'h9E000321, 8, ok, w);
      chk("b2b_wait1", 32'(w), 32'd0);
      send(1, 1, 4'h2, 4'd7, 4'd0, 4'd0, 16'h0001, 32'h2A000107, 8, ok, w);
      chk("b2b_wait2", 32'(w), 32'd0);
      in_valid = 1'b0;
      step();
      step();
      chk("s1_full", 32'(full), 32'd1);
      chk("s1_count", 32'(word_count), 32'd4);
      chk("s1_in_ready", 32'(in_ready), 32'd0);
      chk("s1_wr_en", 32'(mem_wr_en), 32'd0);

      // Restart from FULL, then back-pressure for three cycles
      pulse_start();
      exp_addr = 8'd0;
      chk("rs_count", 32'(word_count), 32'd0);
      chk("rs_addr", 32'(mem_addr), 32'd0);
      chk("rs_full", 32'(full), 32'd0);
      mem_ready = 1'b0;
      xw = enc(0, 1, 4'hA, 4'd8, 4'd9, 4'd0, 16'h1234);
      send(0, 1, 4'hA, 4'd8, 4'd9, 4'd0, 16'h1234, xw, 8, ok, w);
      is_cmp = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_wr_en", 32'(mem_wr_en), 32'd1);
         chk("stall_addr", 32'(mem_addr), 32'd0);
         chk("stall_data", mem_wdata, xw);
         step();
      end
      mem_ready = 1'b1;
      send(1, 0, 4'h5, 4'd4, 4'd3, 4'd2, 16'h0,
           enc(1, 0, 4'h5, 4'd4, 4'd3, 4'd2, 16'h0), 8, ok, w);
      chk("resume_wait", 32'(w), 32'd0);
      send(0, 0, 4'hF, 4'd15, 4'd14, 4'd13, 16'h0,
           enc(0, 0, 4'hF, 4'd15, 4'd14, 4'd13, 16'h0), 8, ok, w);
      chk("resume_b2b", 32'(w), 32'd0);
      in_valid = 1'b0;
      step();
      step();
      chk("stall_count", 32'(word_count), 32'd3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
      chk("stop_idle", 32'(busy), 32'd0);
      chk("stop_hold", 32'(word_count), 32'd3);

      // Stream six bundles into a four-word session
      pulse_start();
      exp_addr = 8'd0;
      snap = wr_cnt;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         send(i[0], i[1], 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3),
              16'(16'h1111 * i),
              enc(i[0], i[1], 4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3),
                  16'(16'h1111 * i)), 6, ok, w);
         if (ok)
            acc++;
      end
      in_valid = 1'b0;
      step();
      chk("cap_accepted", 32'(acc), 32'd4);
      chk("cap_writes", 32'(wr_cnt - snap), 32'd4);
      chk("cap_full", 32'(full), 32'd1);
      chk("cap_in_ready", 32'(in_ready), 32'd0);
      chk("cap_count", 32'(word_count), 32'd4);
      pulse_start();
      exp_addr = 8'd0;
      chk("cap_rs_count", 32'(word_count), 32'd0);
      chk("cap_rs_addr", 32'(mem_addr), 32'd0);
      chk("cap_rs_busy", 32'(busy), 32'd1);
      send(1, 1, 4'h3, 4'd2, 4'd1, 4'd0, 16'hCAFE,
           enc(1, 1, 4'h3, 4'd2, 4'd1, 4'd0, 16'hCAFE), 8, ok, w);
      in_valid = 1'b0;
      step();
      chk("cap_rs_write", 32'(word_count), 32'd1);

      // Stop in the same cycle as an accepted bundle under back-pressure
      mem_ready = 1'b0;
      stop = 1'b1;
      send(0, 0, 4'h7, 4'd6, 4'd5, 4'd4, 16'h0,
           enc(0, 0, 4'h7, 4'd6, 4'd5, 4'd4, 16'h0), 8, ok, w);
      stop = 1'b0;
      in_valid = 1'b0;
      chk("drain_accept", 32'(ok), 32'd1);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_wr_en", 32'(mem_wr_en), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'd1);
      step();
      step();
      chk("drain_hold", 32'(mem_wr_en), 32'd1);
      chk("drain_still", 32'(busy), 32'd1);
      mem_ready = 1'b1;
      step();
      chk("drain_done", 32'(busy), 32'd0);
      chk("drain_wr_off", 32'(mem_wr_en), 32'd0);
      chk("drain_count", 32'(word_count), 32'd2);

      // Reset while a write is pending drops it
      pulse_start();
      exp_addr = 8'd0;
      mem_ready = 1'b0;
      send(1, 0, 4'h1, 4'd1, 4'd1, 4'd1, 16'h0,
           enc(1, 0, 4'h1, 4'd1, 4'd1, 4'd1, 16'h0), 8, ok, w);
      in_valid = 1'b0;
      chk("mid_wr_en", 32'(mem_wr_en), 32'd1);
      snap = wr_cnt;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr), 32'd0);
      chk("mid_rst_wdata", mem_wdata, 32'd0);
      chk("mid_rst_count", 32'(word_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      mem_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      step();
      chk("mid_no_write", 32'(wr_cnt - snap), 32'd0);
      chk("mid_idle_wr_en", 32'(mem_wr_en), 32'd0);
      chk("mid_idle_busy", 32'(busy), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
